// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle,
    StDone,
    StErr
  } tx_state_e;

  localparam logic [7:0] Ps2CmdReset  = 8'hFF;
  localparam logic [7:0] Ps2CmdEnable = 8'hF4;
  localparam logic [7:0] Ps2Ack       = 8'hFA;

  localparam int unsigned Ps2InhibitCycles = 6000;
  localparam int unsigned Ps2TimeoutCycles = 750000;
  localparam int unsigned Ps2FilterLen     = 8;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-flop synchronisers, clock glitch filter and falling-edge strobe.
module ps2_line_sync #(
  parameter int unsigned FilterLen = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt_o,
  output logic data_sync_o,
  output logic fall_o
);

  localparam int unsigned FiltW = $clog2(FilterLen + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FilterLen - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_filt_q, clk_filt_d;
  logic             clk_prev_q;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

  // A new level is accepted only after FilterLen consecutive differing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  // Idle bus level is high, so everything resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_filt_q  <= clk_filt_d;
      clk_prev_q  <= clk_filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign clk_filt_o  = clk_filt_q;
  assign data_sync_o = data_sync_q[1];
  assign fall_o      = clk_prev_q & ~clk_filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned InhibitCycles = Ps2InhibitCycles,
  parameter int unsigned TimeoutCycles = Ps2TimeoutCycles,
  parameter int unsigned FilterLen     = Ps2FilterLen
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned CntMax = (InhibitCycles > TimeoutCycles) ? InhibitCycles
                                                                   : TimeoutCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(InhibitCycles - 1);
  localparam logic [CntW-1:0] TimeoutLim  = CntW'(TimeoutCycles);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            clk_filt, data_sync, fall;
  logic            timeout;

  ps2_line_sync #(
    .FilterLen(FilterLen)
  ) u_line_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_filt_o (clk_filt),
    .data_sync_o(data_sync),
    .fall_o     (fall)
  );

  assign timeout = (cnt_q == TimeoutLim);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CntW'(1);
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tx_busy_o     = 1'b1;
    tx_done_o     = 1'b0;
    tx_error_o    = 1'b0;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_busy_o = 1'b0;
        cnt_d     = '0;
        if (tx_start_i) begin
          // Frame shifted out LSB first: D0..D7, parity, stop.
          shift_d   = {1'b1, odd_parity(tx_data_i), tx_data_i};
          bit_cnt_d = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt_q == InhibitLast) begin
          ps2_data_oe_o = 1'b1;
          cnt_d         = '0;
          state_d       = StRts;
        end
      end
      StRts: begin
        ps2_data_oe_o = 1'b1;
        if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = 4'd1;
          state_d   = StShift;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StShift: begin
        ps2_data_oe_o = ~shift_q[0];
        if (fall) begin
          cnt_d     = '0;
          shift_d   = {1'b1, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StAck;
          end
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StAck: begin
        if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = (bit_cnt_q == 4'd11) ? bit_cnt_q : bit_cnt_q + 4'd1;
          state_d   = data_sync ? StErr : StWaitIdle;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StWaitIdle: begin
        if (clk_filt && data_sync) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StDone: begin
        tx_busy_o = 1'b0;
        tx_done_o = 1'b1;
        cnt_d     = '0;
        state_d   = StIdle;
      end
      StErr: begin
        tx_busy_o  = 1'b0;
        tx_error_o = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: begin
        tx_busy_o = 1'b0;
        cnt_d     = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '1;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a frame-bit scoreboard.
module tb_ps2_host_tx;

  localparam int unsigned Inhibit = 6000;
  localparam int unsigned Timeout = 3000;
  localparam int unsigned Filt    = 8;
  localparam int unsigned Half    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0, e0;
  logic exp_q[$];

  // Open-drain bus: either side can pull low.
  assign ps2_clk_pin  = dev_clk & ~clk_oe;
  assign ps2_data_pin = dev_data & ~data_oe;

  ps2_host_tx #(
    .InhibitCycles(Inhibit),
    .TimeoutCycles(Timeout),
    .FilterLen    (Filt)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_data_i    (tx_data),
    .tx_start_i   (tx_start),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_error_o   (tx_error),
    .ps2_clk_i    (ps2_clk_pin),
    .ps2_data_i   (ps2_data_pin),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    int hi;
    int first_doe;
    hi = 0;
    first_doe = 0;
    tick();
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
    check("busy_after_start", tx_busy, 1);
    while (clk_oe === 1'b1 && hi < int'(Inhibit) + 100) begin
      hi++;
      if (data_oe === 1'b1 && first_doe == 0) first_doe = hi;
      tick();
    end
    check("inhibit_len", hi, Inhibit);
    check("start_bit_cycle", first_doe, Inhibit);
    check("rts_data_oe", data_oe, 1);
  endtask

  // Device clocks nfalls falls; rst_at/stop_at cut the frame at that fall (0 = never).
  task automatic device_frame(input int nfalls, input logic ack, input int rst_at,
                              input int stop_at, input logic poke);
    logic exp_b;
    int   n;
    repeat (30) tick();
    check("rts_line_low", ps2_data_pin, 0);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_busy", tx_busy, 0);
        return;
      end
      if (i == stop_at) begin
        n = 0;
        while (tx_error !== 1'b1 && n < int'(Timeout) + 200) begin
          tick();
          n++;
          if (n == int'(Half)) dev_clk = 1'b1;
        end
        // Pin-to-strobe latency is 2 sync + Filt filter + 1 strobe cycle, then FSM register.
        check("timeout_latency", n, Timeout + Filt + 4);
        check("timeout_clk_oe", clk_oe, 0);
        check("timeout_data_oe", data_oe, 0);
        check("timeout_busy", tx_busy, 0);
        return;
      end
      if (poke && i == 3) begin
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("start_while_busy", tx_busy, 1);
        repeat (Half - 1) tick();
      end else begin
        repeat (Half) tick();
      end
      if (i <= 10) begin
        check($sformatf("sb_nonempty_%0d", i), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check($sformatf("frame_bit_%0d", i), ps2_data_pin, exp_b);
        end
      end
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
      if (i == nfalls) return;
      if (poke && i == 6) begin
        repeat (8) tick();
        dev_clk = 1'b0;
        repeat (2) tick();
        dev_clk = 1'b1;
        repeat (Half - 10) tick();
      end else begin
        repeat (Half) tick();
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("done_seen", tx_done, 1);
    check("no_error_with_done", tx_error, 0);
    check("busy_low_at_done", tx_busy, 0);
    tx_data  = 8'h12;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("done_one_cycle", tx_done, 0);
    tick();
    check("start_in_done_ignored", tx_busy, 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_error", tx_error, 0);
    check("reset_clk_oe", clk_oe, 0);
    check("reset_data_oe", data_oe, 0);
    rst = 1'b0;
    repeat (20) tick();

    // Enable-reporting command, normal ACK.
    d0 = done_cnt;
    start_tx(8'hF4);
    device_frame(11, 1'b1, 0, 0, 1'b0);
    wait_done();
    check("t1_done_count", done_cnt - d0, 1);

    // Parity corner cases.
    start_tx(8'hFF);
    device_frame(11, 1'b1, 0, 0, 1'b0);
    wait_done();
    start_tx(8'h00);
    device_frame(11, 1'b1, 0, 0, 1'b0);
    wait_done();

    // Missing ACK.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h3C);
    device_frame(11, 1'b0, 0, 0, 1'b0);
    repeat (50) tick();
    check("nak_error_count", err_cnt - e0, 1);
    check("nak_no_done", done_cnt - d0, 0);
    check("nak_clk_oe", clk_oe, 0);
    check("nak_data_oe", data_oe, 0);
    check("nak_busy", tx_busy, 0);
    exp_q.delete();

    // Device stops clocking after fall 5.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hF4);
    device_frame(11, 1'b1, 0, 5, 1'b0);
    repeat (20) tick();
    check("timeout_error_count", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    exp_q.delete();
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (30) tick();

    // Reset mid-frame, then a clean frame.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hF4);
    device_frame(11, 1'b1, 4, 0, 1'b0);
    repeat (3) tick();
    rst      = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    exp_q.delete();
    repeat (30) tick();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_error", err_cnt - e0, 0);
    check("rst_idle_busy", tx_busy, 0);
    start_tx(8'hF4);
    device_frame(11, 1'b1, 0, 0, 1'b0);
    wait_done();

    // Start while shifting is ignored; short clock glitch is filtered.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h5C);
    device_frame(11, 1'b1, 0, 0, 1'b1);
    wait_done();
    repeat (5) tick();
    check("poke_done_count", done_cnt - d0, 1);
    check("poke_no_error", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
